fifo_feed_ctrl: RTL and testbench

Sequencer for a bank of DIM delay-buffer FIFO lanes (each DIM deep) that feed a DIM×DIM systolic array.
- Fills all lanes in lockstep from a valid/ready source, one beat per accepted cycle.
- Drains the lanes with a one-cycle-per-lane diagonal skew, so operands enter the array wavefront-aligned.
- Drives the per-lane shift enables and the array enable. Reports busy/done to the top-level command logic.

---
 rtl/feed_ctrl_pkg.sv | 24 ++
 rtl/fifo_feed_ctrl_skew_mask_gen.sv | 35 +++
 rtl/fifo_feed_ctrl.sv | 132 +++++++++++++
 tb/tb_fifo_feed_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/feed_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : feed_ctrl_pkg
// Brief  : Shared types and helpers for the FIFO feed sequencer and its
//          skew-mask generator (also used by the B-operand controller).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
package feed_ctrl_pkg;

    // Sequencer states; IDLE is the reset state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_t;

    // Number of drain cycles for a diagonally skewed DIM-lane bank
    function automatic int drain_len(input int dim);
        return 2 * dim - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_feed_ctrl_skew_mask_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : skew_mask_gen
// Brief  : Combinational diagonal-skew mask. Lane i is live while the drain
//          counter d satisfies i <= d < i+DIM; the shift enable is further
//          gated by the global stall. Not state-aware: callers gate it.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module skew_mask_gen #(
    parameter int DIM   = 8,
    parameter int CNT_W = $clog2(2 * DIM)
) (
    input  logic [CNT_W-1:0] i_drain_cnt,
    input  logic             i_hold,
    output logic [DIM-1:0]   o_fifo_en,
    output logic [DIM-1:0]   o_lane_valid
);

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        // Window bounds for this lane; i+DIM <= 2*DIM-1 always fits CNT_W bits
        localparam logic [CNT_W-1:0] c_LO = CNT_W'(i);
        localparam logic [CNT_W-1:0] c_HI = CNT_W'(i + DIM);

        logic w_in_window;

        // Lane is inside its DIM-cycle drain window
        always_comb begin
            w_in_window     = (i_drain_cnt >= c_LO) && (i_drain_cnt < c_HI);
            o_lane_valid[i] = w_in_window;
            o_fifo_en[i]    = w_in_window && !i_hold;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_feed_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : fifo_feed_ctrl
// Brief  : Sequencer for DIM delay-buffer FIFO lanes feeding a DIMxDIM
//          systolic array: lockstep fill from a valid/ready source, then a
//          diagonally skewed drain, then a one-cycle done pulse.
//          Optional macro FEED_CTRL_PERF_EN adds a saturating stall counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module fifo_feed_ctrl
    import feed_ctrl_pkg::*;
#(
    parameter int DIM = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic           i_hold,
    input  logic           i_src_valid,
    output logic           o_src_ready,
    output logic [DIM-1:0] o_fifo_en,
    output logic [DIM-1:0] o_lane_valid,
    output logic           o_array_en,
    output logic           o_busy,
`ifdef FEED_CTRL_PERF_EN
    output logic [31:0]    o_perf_stall_cnt,
`endif
    output logic           o_done
);

    localparam int                CNT_W        = $clog2(2 * DIM);
    localparam logic [CNT_W-1:0]  c_FILL_LAST  = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0]  c_DRAIN_LAST = CNT_W'(drain_len(DIM) - 1);

    feed_state_t      r_state;
    feed_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_fill_cnt;
    logic [CNT_W-1:0] r_drain_cnt;
    logic             w_beat;
    logic             w_start_ok;
    logic [DIM-1:0]   w_mask_en;
    logic [DIM-1:0]   w_mask_lv;

    assign w_beat     = (r_state == FILL) && i_src_valid && !i_hold;
    assign w_start_ok = (r_state == IDLE) && i_start;

    skew_mask_gen #(
        .DIM   (DIM),
        .CNT_W (CNT_W)
    ) u_skew (
        .i_drain_cnt  (r_drain_cnt),
        .i_hold       (i_hold),
        .o_fifo_en    (w_mask_en),
        .o_lane_valid (w_mask_lv)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = FILL;
            FILL:    if (w_beat && (r_fill_cnt == c_FILL_LAST)) w_state_nxt = DRAIN;
            DRAIN:   if (!i_hold && (r_drain_cnt == c_DRAIN_LAST)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fill/drain counters advance only on accepted beats / unstalled drain cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_fill_cnt <= '0;
            end else if (w_beat) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
                if (r_fill_cnt == c_FILL_LAST) r_drain_cnt <= '0;
            end
            if ((r_state == DRAIN) && !i_hold) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end
        end
    end

    // Output decode from state, counters, hold and src_valid
    always_comb begin
        o_src_ready  = 1'b0;
        o_fifo_en    = '0;
        o_lane_valid = '0;
        o_array_en   = 1'b0;
        o_busy       = (r_state != IDLE);
        o_done       = (r_state == DONE);
        case (r_state)
            FILL: begin
                o_src_ready = !i_hold;
                o_fifo_en   = {DIM{w_beat}};
            end
            DRAIN: begin
                o_fifo_en    = w_mask_en;
                o_lane_valid = w_mask_lv;
                o_array_en   = !i_hold;
            end
            default: ;
        endcase
    end

`ifdef FEED_CTRL_PERF_EN
    logic [31:0] r_perf_stall_cnt;
    logic        w_stall;

    assign w_stall          = (r_state != IDLE) &&
                              (i_hold || ((r_state == FILL) && !i_src_valid));
    assign o_perf_stall_cnt = r_perf_stall_cnt;

    // Saturating stall-cycle counter, cleared when a tile is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_perf_stall_cnt <= '0;
        else if (w_start_ok)                             r_perf_stall_cnt <= '0;
        else if (w_stall && (r_perf_stall_cnt != '1))    r_perf_stall_cnt <= r_perf_stall_cnt + 32'd1;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_feed_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_fifo_feed_ctrl
// Brief  : Directed, table-driven bench for fifo_feed_ctrl (DIM=8).
//          Define FEED_CTRL_PERF_EN to also exercise the stall counter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_fifo_feed_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       src_valid = 1'b0;
    logic       hold = 1'b0;
    logic       src_ready, array_en, busy, done;
    logic [7:0] fifo_en, lane_valid;
    logic [19:0] obs;
`ifdef FEED_CTRL_PERF_EN
    logic [31:0] perf;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int perf_done = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic        hold;
        logic [19:0] exp;   // {fifo_en, lane_valid, src_ready, array_en, busy, done}
    } vec_t;

    vec_t tbl [26];

    fifo_feed_ctrl #(.DIM(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_hold       (hold),
        .i_src_valid  (src_valid),
        .o_src_ready  (src_ready),
        .o_fifo_en    (fifo_en),
        .o_lane_valid (lane_valid),
        .o_array_en   (array_en),
        .o_busy       (busy),
`ifdef FEED_CTRL_PERF_EN
        .o_perf_stall_cnt (perf),
`endif
        .o_done       (done)
    );

    assign obs = {fifo_en, lane_valid, src_ready, array_en, busy, done};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    // Drive inputs for the current cycle, then wait for outputs to settle
    task automatic cyc(input logic s, input logic v, input logic h);
        start = s; src_valid = v; hold = h;
        @(negedge clk);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic play_table(input string nm);
        for (int c = 0; c < 26; c++) begin
            cyc(tbl[c].start, tbl[c].valid, tbl[c].hold);
            chk(nm, c, 32'(obs), 32'(tbl[c].exp));
            adv;
        end
    endtask

    // One tile: optional 1/0 source toggling, optional hold window,
    // optional extra start pulses during FILL and during DONE
    task automatic tile_run(input bit toggle, input int h0, input int hn,
                            input bit s_fill, input bit s_done,
                            output int done_c, output int beats, output int drain0);
        int gate_bad;
        done_c = -1; beats = 0; drain0 = -1; gate_bad = 0;
        cyc(1'b1, 1'b1, 1'b0);
        adv;
        for (int c = 1; c <= 60; c++) begin
            automatic logic v = toggle ? (c % 2 == 0) : 1'b1;
            automatic logic h = (h0 >= 0) && (c >= h0) && (c < h0 + hn);
            automatic logic s = s_fill && (c == 3);
            cyc(s, v, h);
            if (src_ready && src_valid) begin
                beats++;
                if (fifo_en != 8'hFF) gate_bad++;
            end else if (!array_en && fifo_en != 8'h00) begin
                gate_bad++;
            end
            if (array_en && drain0 < 0) drain0 = c;
            if (h) chk("hold_frozen", c, 32'({fifo_en, array_en, lane_valid}), 32'({8'h00, 1'b0, 8'h3F}));
            if (h0 >= 0 && c == h0 + hn) chk("resume_d5", c, 32'(fifo_en), 32'h3F);
            if (done) begin
                done_c = c;
`ifdef FEED_CTRL_PERF_EN
                perf_done = int'(perf);
`endif
                if (s_done) start = 1'b1;
            end
            adv;
            if (done_c >= 0) break;
        end
        chk("enable_gating", 0, 32'(gate_bad), 32'd0);
    endtask

    initial begin
        int done_c, beats, drain0, stray;

        // Expected waveform of an unstalled tile, start in cycle 0
        for (int c = 0; c < 26; c++) begin
            logic [7:0] fe, lv;
            logic rdy, aen, bsy, dn;
            fe = '0; lv = '0; rdy = 0; aen = 0; bsy = 0; dn = 0;
            if (c >= 1 && c <= 8) begin
                rdy = 1; fe = 8'hFF; bsy = 1;
            end else if (c >= 9 && c <= 23) begin
                for (int i = 0; i < 8; i++) lv[i] = ((c - 9) >= i) && ((c - 9) < i + 8);
                fe = lv; aen = 1; bsy = 1;
            end else if (c == 24) begin
                bsy = 1; dn = 1;
            end
            tbl[c].start = (c == 0);
            tbl[c].valid = 1'b1;
            tbl[c].hold  = 1'b0;
            tbl[c].exp   = {fe, lv, rdy, aen, bsy, dn};
        end

        // Reset state
        cyc(1'b0, 1'b1, 1'b0);
        chk("reset_outputs", 0, 32'(obs), 32'd0);
        adv;
        rst = 1'b0;

        // Scenario 1: nominal tile
        play_table("nominal");

        // Scenario 2: source toggling 0/1 during FILL
        tile_run(1'b1, -1, 0, 1'b0, 1'b0, done_c, beats, drain0);
        chk("toggle_beats", 0, 32'(beats), 32'd8);
        chk("toggle_drain_start", 0, 32'(drain0), 32'd17);
        chk("toggle_done_cycle", 0, 32'(done_c), 32'd32);

        // Scenario 3: 3-cycle hold at drain_cnt=5
        tile_run(1'b0, 14, 3, 1'b0, 1'b0, done_c, beats, drain0);
        chk("hold_done_cycle", 0, 32'(done_c), 32'd27);

        // Scenario 4: start during FILL and during DONE is ignored
        tile_run(1'b0, -1, 0, 1'b1, 1'b1, done_c, beats, drain0);
        chk("ignore_done_cycle", 0, 32'(done_c), 32'd24);
        chk("ignore_beats", 0, 32'(beats), 32'd8);
        cyc(1'b0, 1'b1, 1'b0);
        chk("busy_after_done", 25, 32'(busy), 32'd0);
        adv;
        stray = 0;
        for (int c = 26; c < 36; c++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (obs != 20'd0) stray++;
            adv;
        end
        chk("no_second_tile", 0, 32'(stray), 32'd0);

        // Scenario 5: asynchronous reset at drain_cnt=7
        cyc(1'b1, 1'b1, 1'b0);
        adv;
        for (int c = 1; c < 16; c++) begin
            cyc(1'b0, 1'b1, 1'b0);
            adv;
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("pre_reset_d7", 16, 32'({fifo_en, lane_valid, array_en}), 32'({8'hFF, 8'hFF, 1'b1}));
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", 16, 32'(obs), 32'd0);
        adv;
        rst = 1'b0;
        play_table("after_reset");

`ifdef FEED_CTRL_PERF_EN
        // Scenario 6: toggling source plus hold at drain_cnt=5
        tile_run(1'b1, 22, 3, 1'b0, 1'b0, done_c, beats, drain0);
        chk("perf_done_cycle", 0, 32'(done_c), 32'd35);
        chk("perf_at_done", 0, 32'(perf_done), 32'd11);
        cyc(1'b0, 1'b0, 1'b1);
        chk("perf_idle_hold", 0, perf, 32'd11);
        adv;
        cyc(1'b1, 1'b1, 1'b0);
        adv;
        cyc(1'b0, 1'b1, 1'b0);
        chk("perf_cleared", 1, perf, 32'd0);
        adv;
        for (int c = 2; c < 40; c++) begin
            cyc(1'b0, 1'b1, 1'b0);
            adv;
            if (done) break;
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk("perf_unstalled_tile", 0, perf, 32'd0);
        adv;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
